// File: rtl/jtkunio_rom_arb_if.sv
// Bus bundle between the ROM arbiter, its three byte-wide requesters and the SDRAM bank.
// The slave modport is the arbiter's view; master is the environment (CPUs plus SDRAM controller).
interface jtkunio_rom_arb_if #(
    parameter int unsigned AW0 = 16,
    parameter int unsigned AW1 = 15,
    parameter int unsigned AW2 = 17
);
    logic [AW0-1:0] slot0_addr;
    logic           slot0_cs;
    logic           slot0_ok;
    logic [7:0]     slot0_data;

    logic [AW1-1:0] slot1_addr;
    logic           slot1_cs;
    logic           slot1_ok;
    logic [7:0]     slot1_data;

    logic [AW2-1:0] slot2_addr;
    logic           slot2_cs;
    logic           slot2_ok;
    logic [7:0]     slot2_data;

    logic           downloading;
    logic [21:0]    ba_addr;
    logic           ba_rd;
    logic           ba_ack;
    logic           ba_rdy;
    logic [15:0]    data_read;

    modport slave (
        input  slot0_addr, slot0_cs, slot1_addr, slot1_cs, slot2_addr, slot2_cs,
        input  downloading, ba_ack, ba_rdy, data_read,
        output slot0_ok, slot0_data, slot1_ok, slot1_data, slot2_ok, slot2_data,
        output ba_addr, ba_rd
    );

    modport master (
        output slot0_addr, slot0_cs, slot1_addr, slot1_cs, slot2_addr, slot2_cs,
        output downloading, ba_ack, ba_rdy, data_read,
        input  slot0_ok, slot0_data, slot1_ok, slot1_data, slot2_ok, slot2_data,
        input  ba_addr, ba_rd
    );
endinterface

// File: rtl/jtkunio_rom_arb.sv
// Three-slot SDRAM ROM arbiter: each byte requester has a one-word cache, misses are
// served one at a time in round-robin order.
module jtkunio_rom_arb #(
    parameter int unsigned AW0  = 16,
    parameter int unsigned AW1  = 15,
    parameter int unsigned AW2  = 17,
    parameter logic [21:0] OFF0 = 22'h0,
    parameter logic [21:0] OFF1 = 22'h8000,
    parameter logic [21:0] OFF2 = 22'hC000
) (
    input  logic             clk,
    input  logic             rst,
    jtkunio_rom_arb_if.slave bus
);
    localparam int unsigned NS = 3;
    localparam int unsigned WW = 22;
    localparam int unsigned DW = 16;
    localparam int unsigned SW = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   last_q, last_d;
    logic            taint_q, taint_d;
    logic            ba_rd_q, ba_rd_d;
    logic [WW-1:0]   ba_addr_q, ba_addr_d;
    logic [NS-1:0]   valid_q, valid_d;
    logic [WW-1:0]   tag_q  [NS];
    logic [WW-1:0]   tag_d  [NS];
    logic [DW-1:0]   data_q [NS];
    logic [DW-1:0]   data_d [NS];

    logic [WW-1:0]   wa_c [NS];
    logic [NS-1:0]   cs_c;
    logic [NS-1:0]   hit_c;
    logic [NS-1:0]   pend_c;
    logic [SW-1:0]   pick_c;
    logic [WW-1:0]   pick_wa_c;
    logic            fill_c;

    // Word address per slot, hit detection and pending requests
    always_comb begin
        wa_c[0] = WW'(bus.slot0_addr[AW0-1:1]) + OFF0;
        wa_c[1] = WW'(bus.slot1_addr[AW1-1:1]) + OFF1;
        wa_c[2] = WW'(bus.slot2_addr[AW2-1:1]) + OFF2;
        cs_c    = {bus.slot2_cs, bus.slot1_cs, bus.slot0_cs};
        hit_c   = '0;
        for (int i = 0; i < int'(NS); i++) begin
            hit_c[i] = cs_c[i] & valid_q[i] & (tag_q[i] == wa_c[i]);
        end
        pend_c = cs_c & ~hit_c & {NS{~bus.downloading}};
    end

    // Round-robin pick: search starts just after the last served slot
    always_comb begin
        pick_c = 2'd0;
        case (last_q)
            2'd0:    pick_c = pend_c[1] ? 2'd1 : (pend_c[2] ? 2'd2 : 2'd0);
            2'd1:    pick_c = pend_c[2] ? 2'd2 : (pend_c[0] ? 2'd0 : 2'd1);
            default: pick_c = pend_c[0] ? 2'd0 : (pend_c[1] ? 2'd1 : 2'd2);
        endcase
        pick_wa_c = wa_c[0];
        for (int i = 0; i < int'(NS); i++) begin
            if (pick_c == SW'(i)) pick_wa_c = wa_c[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        ba_rd_d   = ba_rd_q;
        ba_addr_d = ba_addr_q;
        taint_d   = taint_q | bus.downloading;
        valid_d   = bus.downloading ? '0 : valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        fill_c    = 1'b0;

        case (state_q)
            IDLE: begin
                taint_d = 1'b0;
                ba_rd_d = 1'b0;
                if (|pend_c) begin
                    sel_d     = pick_c;
                    ba_addr_d = pick_wa_c;
                    ba_rd_d   = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.ba_ack) begin
                    ba_rd_d = 1'b0;
                    if (bus.ba_rdy) begin
                        fill_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (bus.ba_rdy) begin
                    fill_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                ba_rd_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // A download seen at any point of the transfer leaves the filled word invalid
        if (fill_c) begin
            last_d = sel_q;
            for (int i = 0; i < int'(NS); i++) begin
                if (sel_q == SW'(i)) begin
                    tag_d[i]   = ba_addr_q;
                    data_d[i]  = bus.data_read;
                    valid_d[i] = ~(bus.downloading | taint_q);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= 2'd2;
            taint_q   <= 1'b0;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
            valid_q   <= '0;
            for (int i = 0; i < int'(NS); i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            taint_q   <= taint_d;
            ba_rd_q   <= ba_rd_d;
            ba_addr_q <= ba_addr_d;
            valid_q   <= valid_d;
            for (int i = 0; i < int'(NS); i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.ba_rd      = ba_rd_q;
    assign bus.ba_addr    = ba_addr_q;
    assign bus.slot0_ok   = hit_c[0];
    assign bus.slot1_ok   = hit_c[1];
    assign bus.slot2_ok   = hit_c[2];
    assign bus.slot0_data = bus.slot0_addr[0] ? data_q[0][15:8] : data_q[0][7:0];
    assign bus.slot1_data = bus.slot1_addr[0] ? data_q[1][15:8] : data_q[1][7:0];
    assign bus.slot2_data = bus.slot2_addr[0] ? data_q[2][15:8] : data_q[2][7:0];
endmodule

// File: doc/jtkunio_rom_arb.md
JTKUNIO_ROM_ARB -- requirements
Module: jtkunio_rom_arb

Interface
REQ-001 Parameter AW0, 16, byte-address width of slot 0 (main CPU ROM).
REQ-002 Parameter AW1, 15, byte-address width of slot 1 (sound CPU ROM).
REQ-003 Parameter AW2, 17, byte-address width of slot 2 (PCM ROM).
REQ-004 Parameters OFF0/OFF1/OFF2, 22'h0/22'h8000/22'hC000, SDRAM word offset of each slot.
REQ-005 Ports: clk in 1 system clock. rst in 1 reset, asynchronous, active-high.
REQ-006 Ports: slotN_addr in AWN byte address; slotN_cs in 1 read request; slotN_ok out 1 data valid; slotN_data out 8 read byte (N=0..2).
REQ-007 Ports: downloading in 1 ROM download active; ba_addr out 22 SDRAM word address; ba_rd out 1 read request; ba_ack in 1 request accepted; ba_rdy in 1 read data complete; data_read in 16 SDRAM data.

Function
REQ-008 The block SHALL share one SDRAM bank among three byte-wide requesters, each backed by a one-word cache (tag = word address, 16-bit data, valid bit).
REQ-009 Word address of slot N SHALL be slotN_addr[AWN-1:1] zero-extended plus OFFN, wrapping modulo 2^22.
REQ-010 Hit = slotN_cs & valid & tag == current word address; slotN_ok SHALL equal hit combinationally, same cycle.
REQ-011 slotN_data SHALL be cache[7:0] when slotN_addr[0]=0, else cache[15:8]; value is don't-care while slotN_ok=0.
REQ-012 A slot SHALL be pending when slotN_cs=1, hit=0 and downloading=0.
REQ-013 FSM states: IDLE, WAIT_ACK, WAIT_RDY.
REQ-014 IDLE: if any slot pending, select one by round-robin, latch its slot index and word address, drive ba_addr with it, ba_rd=1, go WAIT_ACK next cycle; else stay.
REQ-015 Round-robin: search starts at the slot after the last served slot (order 0,1,2 cyclic); after reset slot 0 has highest priority.
REQ-016 WAIT_ACK: hold ba_rd=1 and ba_addr stable until ba_ack=1; on ba_ack drop ba_rd next cycle and go WAIT_RDY.
REQ-017 WAIT_RDY: on ba_rdy=1 write data_read and the latched tag into the selected slot cache, set valid, update last-served pointer, return to IDLE.
REQ-018 ba_ack and ba_rdy high in the same WAIT_ACK cycle SHALL complete the fill as in REQ-017, going directly to IDLE with ba_rd=0.
REQ-019 Fill data is visible: slotN_ok can assert the cycle after the ba_rdy cycle; minimum miss latency from cs to ok with ack/rdy one cycle each is 3 cycles.
REQ-020 slotN_cs dropping or address changing mid-transfer SHALL NOT abort the transfer; the cache fills with the latched tag and ok follows REQ-010.
REQ-021 Only one SDRAM transaction SHALL be outstanding at any time; no new ba_rd in WAIT_ACK/WAIT_RDY.
REQ-022 downloading=1 SHALL clear all valid bits every cycle and block new requests; a transfer in progress completes but its fill leaves valid=0.
REQ-023 ba_rd SHALL be 0 whenever state is IDLE at cycle start with no pending slot.

Reset
REQ-024 On rst=1, immediately: state IDLE, ba_rd=0, ba_addr=0, all valid=0, cache data and tags 0, last-served pointer=2 (slot 0 first), all slotN_ok=0.
REQ-025 Reset asserted mid-transfer SHALL abandon it; after release no stale fill occurs even if ba_rdy arrives.

Verification
REQ-026 Slot0 cs, addr 16'h1235, ack+1, rdy+2, data_read 16'hBEEF -> ba_addr 22'h091A, ok 3 cycles after cs, data 8'hBE; addr 16'h1234 next cycle -> ok same cycle, data 8'hEF, no ba_rd.
REQ-027 All three slots miss simultaneously after reset -> service order 0,1,2; then slot 0 and 2 miss again together -> 0 served before 2 only if last served was 2 (verify order 0 then 2).
REQ-028 Slot1 addr 15'h0002 -> ba_addr 22'h8001; slot2 addr 17'h1FFFF -> ba_addr 22'h1BFFF (offset add, no truncation error).
REQ-029 Slot2 cs dropped in WAIT_ACK -> transfer completes; reasserting cs with same addr gives ok same cycle with no new ba_rd.
REQ-030 downloading pulsed during WAIT_RDY -> after rdy valid=0; subsequent cs with downloading=0 triggers fresh ba_rd; rst during WAIT_ACK -> ba_rd=0 immediately, ok stays 0.
